pc_redirect_unit: RTL and testbench

- Owns the architectural program counter for the 8-bit instruction address space.
- Consumes the branch target produced by the Execute-stage branch adder, plus the branch decision, and redirects fetch.
- Generates IF/ID and ID/EX flush strobes, a fetch-valid qualifier, and a halt/misalignment status.
- Sits between Execute (branch resolution) and the Fetch stage / instruction memory.

---
 rtl/pc_redirect_unit.sv | 126 ++++++++++++
 tb/tb_pc_redirect_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// +--------------------------------------------------------------------------+
// | pc_redirect_unit: architectural PC, branch redirect, flush and halt.     |
// | Optional branch statistics counter: define BRANCH_STATS_EN.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_redirect_unit #(
  parameter int               PC_W     = 8,
  parameter int               PC_STEP  = 4,
  parameter logic [PC_W-1:0]  RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            ex_valid_i,
  input  logic            ex_branch_i,
  input  logic            ex_zero_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            flush_ifid_o,
  output logic            flush_idex_o,
  output logic            misalign_o,
`ifdef BRANCH_STATS_EN
  output logic            halted_o,
  output logic [15:0]     taken_cnt_o
`else
  output logic            halted_o
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            misalign_q;
  logic            misalign_d;
  logic            first_q;
  logic            take;
  logic            bad;
  logic            redirect;
  logic            flush;

  assign take = ex_valid_i & ex_branch_i & ex_zero_i;
  assign bad  = take & (branch_target_i[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    flush      = 1'b0;
    redirect   = 1'b0;
    case (state_q)
      RUN, BUBBLE: begin
        if (take) begin
          flush = 1'b1;
          if (bad) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            redirect = 1'b1;
            pc_d     = branch_target_i;
            state_d  = BUBBLE;
          end
        end else if (state_q == BUBBLE) begin
          // The bubble exists only while imem reads the target; decode is empty.
          state_d = RUN;
        end else if (halt_i) begin
          state_d = HALT;
        end else if (!stall_i) begin
          pc_d = pc_q + PC_W'(PC_STEP);
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      first_q    <= 1'b0;
    end
  end

  // Flushes are gated by reset so an asynchronous reset kills a redirect at once.
  assign flush_ifid_o  = flush & reset;
  assign flush_idex_o  = flush & reset;
  assign pc_o          = pc_q;
  assign fetch_valid_o = (state_q == RUN) & ~first_q;
  assign misalign_o    = misalign_q;
  assign halted_o      = (state_q == HALT);

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_cnt <= 16'h0000;
    end else if (redirect && (taken_cnt != 16'hFFFF)) begin
      taken_cnt <= taken_cnt + 16'h0001;
    end
  end

  assign taken_cnt_o = taken_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// Directed table-driven bench for pc_redirect_unit plus reset/halt/statistics sequences.
`default_nettype none

module tb_pc_redirect_unit;

  logic       clk;
  logic       reset;
  logic       stall_i;
  logic       halt_i;
  logic       ex_valid_i;
  logic       ex_branch_i;
  logic       ex_zero_i;
  logic [7:0] branch_target_i;
  logic [7:0] pc_o;
  logic       fetch_valid_o;
  logic       flush_ifid_o;
  logic       flush_idex_o;
  logic       misalign_o;
  logic       halted_o;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_o;
`endif

  int n_chk;
  int n_fail;

  pc_redirect_unit #(.PC_W(8), .PC_STEP(4), .RESET_PC(8'h00)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .halt_i          (halt_i),
    .ex_valid_i      (ex_valid_i),
    .ex_branch_i     (ex_branch_i),
    .ex_zero_i       (ex_zero_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc_o),
    .fetch_valid_o   (fetch_valid_o),
    .flush_ifid_o    (flush_ifid_o),
    .flush_idex_o    (flush_idex_o),
    .misalign_o      (misalign_o),
`ifdef BRANCH_STATS_EN
    .halted_o        (halted_o),
    .taken_cnt_o     (taken_cnt_o)
`else
    .halted_o        (halted_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       halt;
    logic       valid;
    logic       branch;
    logic       zero;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic       fv;
    logic       fl;
    logic       mis;
    logic       hlt;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic v, input logic b,
                       input logic z, input logic [7:0] t);
    stall_i = s; halt_i = h; ex_valid_i = v; ex_branch_i = b; ex_zero_i = z; branch_target_i = t;
  endtask

  task automatic check_all(input int idx, input logic [7:0] pc, input logic fv, input logic fl,
                           input logic mis, input logic hlt);
    chk("pc", idx, {8'h00, pc_o}, {8'h00, pc});
    chk("fetch_valid", idx, {15'h0, fetch_valid_o}, {15'h0, fv});
    chk("flush_ifid", idx, {15'h0, flush_ifid_o}, {15'h0, fl});
    chk("flush_idex", idx, {15'h0, flush_idex_o}, {15'h0, fl});
    chk("misalign", idx, {15'h0, misalign_o}, {15'h0, mis});
    chk("halted", idx, {15'h0, halted_o}, {15'h0, hlt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    //          stall halt valid br zero tgt     pc     fv fl mis hlt
    vec[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h08, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF8, 8'h24, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF8, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF8, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h42, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[20] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1};
    vec[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state while held in reset.
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    check_all(-1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].stall, vec[i].halt, vec[i].valid, vec[i].branch, vec[i].zero, vec[i].tgt);
      #1;
      check_all(i, vec[i].pc, vec[i].fv, vec[i].fl, vec[i].mis, vec[i].hlt);
      tick();
    end
`ifdef BRANCH_STATS_EN
    chk("taken_cnt_table", NV, taken_cnt_o, 16'd4);
`endif

    // Asynchronous reset aborts a redirect and clears the sticky flags.
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40);
    #1;
    check_all(100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 reset = 1'b1;
    tick();
    // Now in RUN at pc 04; drive a take then pulse reset before the edge.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40);
    #1;
    chk("flush_before_reset", 101, {15'h0, flush_ifid_o}, 16'h0001);
    reset = 1'b0;
    #1;
    chk("flush_during_reset", 102, {15'h0, flush_ifid_o}, 16'h0000);
    chk("pc_during_reset", 102, {8'h00, pc_o}, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    #2 reset = 1'b1;

    // halt_i outranks stall_i; HALT then ignores everything.
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check_all(110, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80);
    #1;
    check_all(111, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_all(112, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef BRANCH_STATS_EN
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    #2 reset = 1'b1;
    chk("taken_cnt_reset", 120, taken_cnt_o, 16'h0000);
    force dut.taken_cnt = 16'hFFFE;
    #1;
    release dut.taken_cnt;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40);
    tick();
    chk("taken_cnt_sat", 121, taken_cnt_o, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80);
    tick();
    chk("taken_cnt_hold", 122, taken_cnt_o, 16'hFFFF);
    chk("pc_back_to_back", 122, {8'h00, pc_o}, 16'h0080);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
